// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the 7-segment display read-back block:
// segment bit positions, the hex glyph table and the filter FSM states.
package seven_segment_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry k is the segment pattern that displays hex digit k.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

endpackage

// File: rtl/seven_segment_decode.sv
// Combinational segment-pattern to nibble decoder; exact match against the
// glyph table, with a separate flag for the all-off (blank) pattern.
import seven_segment_pkg::*;

module seven_segment_decode (
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       is_glyph_o,
  output logic       is_blank_o
);

  always_comb begin
    nibble_o   = '0;
    is_glyph_o = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (seg_i == GLYPHS[k]) begin
        nibble_o   = 4'(k);
        is_glyph_o = 1'b1;
      end
    end
  end

  assign is_blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seven_segment_reader.sv
// Reads back a multiplexed 7-segment display: synchronizes the bus, waits for
// a stable segment/strobe pair, decodes it and stores it per digit.
import seven_segment_pkg::*;

module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic [3:0]              update_idx,
  output logic                    seg_err
);

  localparam int PW = 7 + NUM_DIGITS;

  logic [PW-1:0]         sync1_q, sync2_q, prev_q;
  logic [7:0]            count_q;
  state_e                state_q;
  logic                  cap_q;
  logic [6:0]            cap_seg_q;
  logic [3:0]            cap_idx_q;
  logic [3:0]            nib_q [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] dig_s;
  logic [6:0]            seg_s;
  logic                  same;
  logic                  onehot;
  logic [3:0]            idx_d;
  logic [3:0]            dec_nibble;
  logic                  dec_glyph;
  logic                  dec_blank;

  assign dig_s  = sync2_q[NUM_DIGITS-1:0];
  assign seg_s  = sync2_q[PW-1:NUM_DIGITS];
  assign same   = (sync2_q == prev_q);
  assign onehot = (dig_s != '0) && ((dig_s & (dig_s - NUM_DIGITS'(1))) == '0);

  always_comb begin
    idx_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_s[k]) idx_d = idx_d | 4'(k);
    end
  end

  // Filter FSM; the capture is staged one cycle in cap_* before it hits the bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      cap_q     <= 1'b0;
      cap_seg_q <= '0;
      cap_idx_q <= '0;
    end else begin
      sync1_q <= {seg_in, dig_in};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cap_q   <= 1'b0;
      if (!same) begin
        count_q <= '0;
        state_q <= onehot ? SETTLE : IDLE;
      end else begin
        if (count_q != 8'hFF) count_q <= count_q + 8'd1;
        if (state_q == SETTLE && count_q == 8'(STABLE_CYCLES - 1)) begin
          state_q   <= HELD;
          cap_q     <= 1'b1;
          cap_seg_q <= seg_s;
          cap_idx_q <= idx_d;
        end
      end
    end
  end

  seven_segment_decode u_decode (
    .seg_i      (cap_seg_q),
    .nibble_o   (dec_nibble),
    .is_glyph_o (dec_glyph),
    .is_blank_o (dec_blank)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update      <= 1'b0;
      update_idx  <= '0;
      seg_err     <= 1'b0;
      digit_valid <= '0;
      digit_blank <= '1;
      for (int k = 0; k < NUM_DIGITS; k++) nib_q[k] <= '0;
    end else begin
      update  <= cap_q;
      seg_err <= cap_q && !dec_glyph && !dec_blank;
      if (cap_q) update_idx <= cap_idx_q;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap_q && cap_idx_q == 4'(k)) begin
          if (dec_glyph) begin
            nib_q[k]       <= dec_nibble;
            digit_valid[k] <= 1'b1;
            digit_blank[k] <= 1'b0;
          end else begin
            digit_valid[k] <= 1'b0;
            digit_blank[k] <= dec_blank;
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_out
      assign digits_out[4*gi +: 4] = nib_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_seven_segment_reader.sv
// Randomized and directed bench for seven_segment_reader, checked every cycle
// against a history-based model of the stability filter.
module tb_seven_segment_reader;

  localparam int N = 4;
  localparam int S = 8;
  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [6:0]     seg_in = '0;
  logic [N-1:0]   dig_in = '0;
  logic [4*N-1:0] digits_out;
  logic [N-1:0]   digit_valid;
  logic [N-1:0]   digit_blank;
  logic           update;
  logic [3:0]     update_idx;
  logic           seg_err;

  always #5 clk = ~clk;

  seven_segment_reader #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .dig_in      (dig_in),
    .digits_out  (digits_out),
    .digit_valid (digit_valid),
    .digit_blank (digit_blank),
    .update      (update),
    .update_idx  (update_idx),
    .seg_err     (seg_err)
  );

  int tests = 0;
  int fails = 0;

  // Raw {seg,dig} pair seen at each clock edge since reset release.
  logic [6+N:0]   hist [$];
  logic [3:0]     m_nib [N];
  logic [N-1:0]   m_valid, m_blank;
  logic           m_upd, m_err;
  logic [3:0]     m_idx;
  logic [4*N-1:0] m_digits;

  int upd_count = 0;
  int err_count = 0;
  int last_upd_edge = -1;
  int upd_log [$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6+N:0] h(int k);
    if (k < 0 || k >= hist.size()) return '0;
    return hist[k];
  endfunction

  function automatic int glyph_val(logic [6:0] p);
    for (int k = 0; k < 16; k++) if (TBL[k] == p) return k;
    return -1;
  endfunction

  // A capture lands at edge n when the pair seen at edges n-S-3..n-3 is one
  // run of S+1 identical samples that began right there and shows one strobe.
  always @(posedge clk or posedge reset) begin
    m_upd = 1'b0;
    m_err = 1'b0;
    if (reset) begin
      hist.delete();
      for (int k = 0; k < N; k++) m_nib[k] = '0;
      m_valid = '0;
      m_blank = '1;
      m_idx   = '0;
    end else begin
      int n;
      logic [6+N:0] v;
      bit run_ok;
      hist.push_back({seg_in, dig_in});
      n = hist.size() - 1;
      v = h(n - S - 3);
      run_ok = (h(n - S - 4) != v) && ($countones(v[N-1:0]) == 1);
      for (int j = 1; j <= S; j++) if (h(n - S - 3 + j) != v) run_ok = 0;
      if (run_ok) begin
        int di, g;
        di = 0;
        for (int k = 0; k < N; k++) if (v[k]) di = k;
        g = glyph_val(v[6+N:N]);
        m_upd = 1'b1;
        m_idx = 4'(di);
        if (g >= 0) begin
          m_nib[di] = 4'(g);
          m_valid[di] = 1'b1;
          m_blank[di] = 1'b0;
        end else if (v[6+N:N] == 7'h00) begin
          m_valid[di] = 1'b0;
          m_blank[di] = 1'b1;
        end else begin
          m_valid[di] = 1'b0;
          m_blank[di] = 1'b0;
          m_err = 1'b1;
        end
      end
    end
    for (int k = 0; k < N; k++) m_digits[4*k +: 4] = m_nib[k];
    #1;
    check("update", 32'(update), 32'(m_upd));
    check("seg_err", 32'(seg_err), 32'(m_err));
    check("digits_out", 32'(digits_out), 32'(m_digits));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("digit_blank", 32'(digit_blank), 32'(m_blank));
    if (m_upd) check("update_idx", 32'(update_idx), 32'(m_idx));
    if (update) begin
      upd_count++;
      upd_log.push_back(int'(update_idx));
      last_upd_edge = hist.size() - 1;
    end
    if (seg_err) err_count++;
  end

  task automatic drive(logic [6:0] s, logic [N-1:0] d, int cycles);
    seg_in = s;
    dig_in = d;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clear_counts();
    upd_count = 0;
    err_count = 0;
    last_upd_edge = -1;
    upd_log.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);

    // Single steady digit: pulse 11 edges after the first sampling edge.
    seg_in = 7'h5B;
    dig_in = 4'b0001;
    reset = 1'b0;
    clear_counts();
    drive(7'h5B, 4'b0001, 20);
    check("t1_pulses", 32'(upd_count), 32'd1);
    check("t1_edge", 32'(last_upd_edge), 32'd11);
    check("t1_nibble", 32'(digits_out[3:0]), 32'h2);
    check("t1_valid", 32'(digit_valid), 32'b0001);

    // Scan all four digits.
    clear_counts();
    drive(7'h4F, 4'b0001, 16);
    drive(7'h7C, 4'b0010, 16);
    drive(7'h39, 4'b0100, 16);
    drive(7'h71, 4'b1000, 16);
    check("t2_digits", 32'(digits_out), 32'hFCB3);
    check("t2_valid", 32'(digit_valid), 32'b1111);
    check("t2_pulses", 32'(upd_count), 32'd4);
    for (int k = 0; k < 4; k++)
      check("t2_idx", (k < upd_log.size()) ? 32'(upd_log[k]) : 32'hFFFF, 32'(k));

    // Short glitch on a held digit: only the return to 7 recaptures.
    drive(7'h07, 4'b0100, 16);
    clear_counts();
    drive(7'h7F, 4'b0100, 5);
    drive(7'h07, 4'b0100, 16);
    check("t3_pulses", 32'(upd_count), 32'd1);
    check("t3_nibble", 32'(digits_out[11:8]), 32'h7);

    // Invalid pattern, then blank, on digit 1.
    clear_counts();
    drive(7'h7E, 4'b0010, 16);
    check("t4_err", 32'(err_count), 32'd1);
    check("t4_valid1", 32'(digit_valid[1]), 32'd0);
    clear_counts();
    drive(7'h00, 4'b0010, 16);
    check("t4_blank1", 32'(digit_blank[1]), 32'd1);
    check("t4_noerr", 32'(err_count), 32'd0);
    check("t4_digits", 32'(digits_out), 32'hF7B3);

    // Multi-hot strobe: nothing captured.
    clear_counts();
    drive(7'h06, 4'b0110, 30);
    check("t5_pulses", 32'(upd_count), 32'd0);
    check("t5_err", 32'(err_count), 32'd0);
    check("t5_digits", 32'(digits_out), 32'hF7B3);
    check("t5_valid", 32'(digit_valid), 32'b1101);
    check("t5_blank", 32'(digit_blank), 32'b0010);

    // Reset while settling discards the pending capture.
    drive(7'h6D, 4'b0001, 5);
    #2 reset = 1'b1;
    #1;
    check("t6_digits", 32'(digits_out), 32'h0);
    check("t6_valid", 32'(digit_valid), 32'h0);
    check("t6_blank", 32'(digit_blank), 32'hF);
    check("t6_update", 32'(update), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clear_counts();
    drive(7'h6D, 4'b0001, 20);
    check("t6_recap", 32'(digits_out[3:0]), 32'h5);
    check("t6_pulses", 32'(upd_count), 32'd1);

    // Random traffic checked by the model every cycle.
    for (int r = 0; r < 200; r++) begin
      logic [6:0] s;
      logic [N-1:0] d;
      int sel;
      sel = $urandom_range(99);
      if (sel < 55) s = TBL[$urandom_range(15)];
      else if (sel < 70) s = 7'h00;
      else s = 7'($urandom);
      sel = $urandom_range(99);
      if (sel < 80) d = N'(1) << $urandom_range(N - 1);
      else if (sel < 90) d = '0;
      else d = N'($urandom);
      drive(s, d, $urandom_range(20, 1));
    end
    drive(seg_in, dig_in, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
Inverse of our nibble-to-segment encoder. Monitors a scanned/multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and reconstructs the hex nibble shown on each digit. Used to read back front-panel and console displays driven by external logic. Contains an input synchronizer, a stability filter, a per-digit register bank, and a combinational pattern decoder.

Parameters:
NUM_DIGITS, 4, number of digit strobes and register-bank entries (range 1..16)
STABLE_CYCLES, 8, consecutive identical synchronized samples required before capture (>=1, <=255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
seg_in  input  7  raw segment lines, active-high; bit0 = A (top), then clockwise B..F, bit6 = G (middle)
dig_in  input  NUM_DIGITS  raw digit strobes, active-high, one-hot when valid
digits_out  output  4*NUM_DIGITS  nibble for digit i at [4i+3:4i]
digit_valid  output  NUM_DIGITS  digit i holds a decoded nibble
digit_blank  output  NUM_DIGITS  last capture for digit i was all-segments-off
update  output  1  one-cycle pulse on every capture
update_idx  output  4  digit index of the capture; valid only while update=1
seg_err  output  1  one-cycle pulse: captured pattern is neither a hex glyph nor blank

Behaviour:
- Reset (async assert, sync release) values: digits_out=0, digit_valid=0, digit_blank=all-ones, update=0, update_idx=0, seg_err=0, synchronizers=0, counter=0, state=IDLE.
- Two-flop synchronizer on every bit of seg_in and dig_in. A one-stage "prev" register holds the last synchronized pair {seg,dig}.
- "same" = synced pair equals prev. Counter: cleared when !same; incremented (saturating) when same.
- FSM:
  - IDLE: synced dig not exactly one-hot (zero or multi-hot). No counting, no capture. Enter SETTLE when dig becomes one-hot.
  - SETTLE: when same and counter==STABLE_CYCLES-1, perform capture and go to HELD. Any change returns counter to 0 and stays in SETTLE; go to IDLE if dig is no longer one-hot.
  - HELD: no further captures while the pair is unchanged. Any change goes to SETTLE (counter 0), or to IDLE if dig is not one-hot.
- Capture, registered on that edge, for index i = position of the set strobe bit:
  - Hex glyph: digits_out[i] <= decoded nibble, digit_valid[i] <= 1, digit_blank[i] <= 0.
  - Pattern 0x00: digit_blank[i] <= 1, digit_valid[i] <= 0, nibble retained.
  - Any other pattern: digit_valid[i] <= 0, digit_blank[i] <= 0, nibble retained, seg_err <= 1.
  - Every capture asserts update=1 with update_idx=i for one cycle. Other digits are untouched.
- Glyph table, seg[6:0] -> nibble: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F. All entries are distinct; the decode is exact-match only.
- Latency: after a pin change that then holds steady, update rises exactly STABLE_CYCLES+3 clk edges after the first edge that samples the new value.
- Glitches shorter than the filter window produce no capture. A strobe that stays unchanged produces exactly one capture.
- Reset mid-SETTLE discards the pending capture and clears everything to reset values.

Decomposition:
- Package seven_segment_pkg:
  - segment-bit index constants (SEG_A..SEG_G);
  - glyph table constant (16 x 7-bit);
  - SEG_BLANK constant;
  - FSM state typedef (IDLE, SETTLE, HELD).
- Sub-module seven_segment_decode: combinational. 7-bit pattern in; outputs nibble, is_glyph, is_blank.
- Onehot-to-index conversion stays inline.

Test Plan:
- Reset mid-traffic -> all outputs at reset values on the next edge; digit_blank=4'b1111.
- seg_in=0x5B, dig_in=4'b0001 held 20 cycles, STABLE_CYCLES=8 -> update pulse at edge 11 with update_idx=0; digits_out[3:0]=2; digit_valid=4'b0001; exactly one pulse.
- Scan digits 0..3 showing 0x4F, 0x7C, 0x39, 0x71, 16 cycles each -> digits_out=16'hFCB3, digit_valid=4'b1111, four update pulses with idx 0,1,2,3.
- Digit 2 holding 0x07, then a 5-cycle glitch to 0x7F -> no new capture; the glitch's return to 0x07 after HELD recaptures 7 and does not produce 8.
- Digit 1 showing 0x7E (invalid) -> seg_err pulse, digit_valid[1]=0; then 0x00 -> digit_blank[1]=1, no seg_err.
- dig_in=4'b0110 held 30 cycles -> no update, no seg_err, registers unchanged.
